// File: rtl/axi_xbar_age_table.sv
//------------------------------------------------------------------------------
// axi_xbar_age_table: per-requester saturating age tracker feeding the crossbar
// arbiter's max selector; entries clear on grant. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axi_xbar_age_table #(
    parameter int WIDTH       = 4,
    parameter int NUM_INPUTS  = 8,
    parameter int INDEX_WIDTH = 3,
    parameter int PRESCALE    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_INPUTS-1:0]       req,
    input  logic                        clear,
    input  logic                        grant_valid,
    input  logic [INDEX_WIDTH-1:0]      grant_index,
    output logic [NUM_INPUTS*WIDTH-1:0] age_vec,
    output logic [NUM_INPUTS-1:0]       active,
    output logic                        any_active,
    output logic [NUM_INPUTS-1:0]       sat,
    output logic                        grant_err
);

    localparam int PW = (PRESCALE > 0) ? PRESCALE : 1;

    logic [NUM_INPUTS-1:0][WIDTH-1:0] age_q, age_d;
    logic                             grant_err_q, grant_err_d;
    logic [NUM_INPUTS-1:0]            w_hit;
    logic                             w_tick;

    generate
        if (PRESCALE == 0) begin : g_no_prescale
            assign w_tick = 1'b1;
        end else begin : g_prescale
            logic [PW-1:0] presc_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) presc_q <= '0;
                else     presc_q <= presc_q + PW'(1);
            end
            assign w_tick = &presc_q;
        end
    endgenerate

    // Activity is derived from the age itself, so active <=> age != 0 by construction.
    always_comb begin
        active = '0;
        sat    = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            active[i] = |age_q[i];
            sat[i]    = &age_q[i];
        end
    end

    always_comb begin
        age_d = age_q;
        w_hit = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_hit[i] = grant_valid && (grant_index == INDEX_WIDTH'(i)) && active[i];
            if (clear || w_hit[i]) begin
                age_d[i] = '0;
            end else if (active[i] && !req[i]) begin
                age_d[i] = '0;
            end else if (!active[i] && req[i]) begin
                age_d[i] = WIDTH'(1);
            end else if (active[i] && w_tick && !sat[i]) begin
                age_d[i] = age_q[i] + WIDTH'(1);
            end
        end
        // An out-of-range index can never match any entry, so it lands here too.
        grant_err_d = grant_valid && !clear && !(|w_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q       <= '0;
            grant_err_q <= 1'b0;
        end else begin
            age_q       <= age_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign age_vec    = age_q;
    assign any_active = |active;
    assign grant_err  = grant_err_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_xbar_age_table.sv
//------------------------------------------------------------------------------
// tb_axi_xbar_age_table: directed self-checking bench for axi_xbar_age_table.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_xbar_age_table;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default configuration: WIDTH=4, NUM_INPUTS=8, PRESCALE=0
    logic [7:0]  req0 = '0;
    logic        clr0 = 1'b0, gv0 = 1'b0;
    logic [2:0]  gi0 = '0;
    logic [31:0] av0;
    logic [7:0]  act0, sat0;
    logic        any0, err0;

    // Six requesters with a 3-bit index (indices 6 and 7 are out of range)
    logic [5:0]  req6 = '0;
    logic        gv6 = 1'b0;
    logic [2:0]  gi6 = '0;
    logic [23:0] av6;
    logic [5:0]  act6, sat6;
    logic        any6, err6;

    // Prescaled configuration: PRESCALE=2
    logic [7:0]  reqp = '0;
    logic [31:0] avp;
    logic [7:0]  actp, satp;
    logic        anyp, errp;

    axi_xbar_age_table #(.WIDTH(4), .NUM_INPUTS(8), .INDEX_WIDTH(3), .PRESCALE(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .clear(clr0), .grant_valid(gv0),
        .grant_index(gi0), .age_vec(av0), .active(act0), .any_active(any0),
        .sat(sat0), .grant_err(err0));

    axi_xbar_age_table #(.WIDTH(4), .NUM_INPUTS(6), .INDEX_WIDTH(3), .PRESCALE(0)) u_dut6 (
        .clk(clk), .rst(rst), .req(req6), .clear(1'b0), .grant_valid(gv6),
        .grant_index(gi6), .age_vec(av6), .active(act6), .any_active(any6),
        .sat(sat6), .grant_err(err6));

    axi_xbar_age_table #(.WIDTH(4), .NUM_INPUTS(8), .INDEX_WIDTH(3), .PRESCALE(2)) u_dutp (
        .clk(clk), .rst(rst), .req(reqp), .clear(1'b0), .grant_valid(1'b0),
        .grant_index(3'd0), .age_vec(avp), .active(actp), .any_active(anyp),
        .sat(satp), .grant_err(errp));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req6 = 6'h01;
        #12;
        chk("rst_age_vec", av0, 0);
        chk("rst_active", act0, 0);
        chk("rst_any", any0, 0);
        chk("rst_sat", sat0, 0);
        chk("rst_err", err0, 0);
        rst = 1'b0;

        // Arrival and aging up to saturation
        req0 = 8'h01;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("age0_k%0d", k), av0[3:0], (k < 15) ? k : 15);
        end
        chk("age_active", act0, 8'h01);
        chk("age_sat", sat0, 8'h01);
        chk("age_any", any0, 1);

        // Grant and re-entry on entry 2
        req0 = 8'h05;
        repeat (5) step();
        chk("pre_grant_vec", av0, 32'h0000_050F);
        gv0 = 1'b1; gi0 = 3'd2;
        step();
        gv0 = 1'b0;
        chk("grant_vec", av0, 32'h0000_000F);
        chk("grant_active", act0, 8'h01);
        chk("grant_err", err0, 0);
        step();
        chk("reentry_vec", av0, 32'h0000_010F);
        chk("reentry_err", err0, 0);

        // Back-to-back illegal grants to inactive entry 3
        gv0 = 1'b1; gi0 = 3'd3;
        step();
        chk("ill1_err", err0, 1);
        chk("ill1_vec", av0, 32'h0000_020F);
        step();
        gv0 = 1'b0;
        chk("ill2_err", err0, 1);
        chk("ill2_vec", av0, 32'h0000_030F);
        step();
        chk("ill_done_err", err0, 0);
        chk("ill_done_vec", av0, 32'h0000_040F);

        // Clear outranks a legal grant and request toggling
        req0 = 8'h07;
        step();
        chk("pre_clear_vec", av0, 32'h0000_051F);
        clr0 = 1'b1; gv0 = 1'b1; gi0 = 3'd1; req0 = 8'hF8;
        step();
        clr0 = 1'b0; gv0 = 1'b0;
        chk("clear_vec", av0, 0);
        chk("clear_active", act0, 0);
        chk("clear_any", any0, 0);
        step();
        chk("clear_err", err0, 0);
        chk("post_clear_vec", av0, 32'h1111_1000);

        // Withdraw entry 4 at age 7
        repeat (6) step();
        chk("pre_wd_age4", av0[19:16], 7);
        req0 = 8'hE8;
        step();
        chk("wd_vec", av0, 32'h8880_8000);
        chk("wd_active", act0, 8'hE8);
        chk("pre_rst_sat6", sat6, 6'h01);

        // Asynchronous reset between edges
        reqp = 8'h01;
        #2 rst = 1'b1;
        #1;
        chk("arst_vec0", av0, 0);
        chk("arst_active0", act0, 0);
        chk("arst_any0", any0, 0);
        chk("arst_sat6", sat6, 0);
        chk("arst_vec6", av6, 0);
        chk("arst_vecp", avp, 0);
        #1 rst = 1'b0;

        // Prescaled aging from reset release, plus restart of the others
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("presc_k%0d", k), avp[3:0], 1 + k / 4);
            if (k == 1) begin
                chk("rearr_vec0", av0, 32'h1110_1000);
                chk("rearr_any0", any0, 1);
            end
        end
        chk("presc_active", actp, 8'h01);

        // Out-of-range grant indices on the six-entry table
        gv6 = 1'b1; gi6 = 3'd7;
        step();
        chk("oor7_err", err6, 1);
        chk("oor7_vec", av6, 24'h00000D);
        gi6 = 3'd6;
        step();
        gv6 = 1'b0;
        chk("oor6_err", err6, 1);
        chk("oor6_vec", av6, 24'h00000E);
        step();
        chk("oor_done_err", err6, 0);
        chk("oor_done_vec", av6, 24'h00000F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_xbar_age_table.md
# axi_xbar_age_table

Per-requester age tracker for the AXI crossbar arbiter, sitting upstream of the combinational min/max selector. It keeps one saturating age counter per requester, clears an entry when the arbiter grants that index back to it, and presents the packed age vector for the selector's max search. The selector reduces the vector to a winning index. This block accepts that index back and updates its state.

## Interface
- WIDTH, 4: age counter width per entry; must be ≥2.
- NUM_INPUTS, 8: number of requesters.
- INDEX_WIDTH, 3: grant index width, equal to ceil(log2(NUM_INPUTS)).
- PRESCALE, 0: ages advance once every 2^PRESCALE cycles; 0 means every cycle.

- clk  in  1  single clock; every register is in this domain.
- rst  in  1  asynchronous reset, active-high.
- req  in  NUM_INPUTS  level request per requester.
- clear  in  1  synchronous flush of every entry.
- grant_valid  in  1  grant strobe from the arbiter.
- grant_index  in  INDEX_WIDTH  index of the granted entry.
- age_vec  out  NUM_INPUTS*WIDTH  packed ages; entry i is at [i*WIDTH +: WIDTH]. An inactive entry reads 0.
- active  out  NUM_INPUTS  entry i currently holds a pending request.
- any_active  out  1  OR of all bits of active.
- sat  out  NUM_INPUTS  entry i age equals 2^WIDTH-1.
- grant_err  out  1  one-cycle pulse flagging an illegal grant.

## Operation
- Per-entry state: active bit and a WIDTH-bit age.
- Invariant: an entry is active if and only if its age ≠ 0.
- Tick:
  - A free-running prescale counter of max(PRESCALE,1) bits runs continuously.
  - tick = 1 when the counter is all ones; with PRESCALE=0, tick is constant 1.
  - The counter is reset only by rst.
- Per-entry update at each clk edge. Priority runs top to bottom; the first match wins:
  1. clear=1: age 0, inactive.
  2. Legal grant to i (grant_valid=1, grant_index=i, i<NUM_INPUTS, entry i active): age 0, inactive, regardless of req[i]. Re-entry happens at the earliest on the following edge.
  3. Active and req[i]=0 (withdraw): age 0, inactive.
  4. Inactive and req[i]=1 (arrival): age 1, active. Arrival ignores tick.
  5. Active, req[i]=1, tick=1: age+1, saturating at 2^WIDTH-1.
  6. Otherwise: hold.
- Illegal grant:
  - Condition: grant_valid=1 with grant_index ≥ NUM_INPUTS, or the indexed entry inactive.
  - Response: no state change; grant_err=1 on the next cycle.
  - When clear=1 in the same cycle, the grant is neither checked nor flagged.
- Only one grant per cycle. Grants to different entries on consecutive cycles are independent.
- Ages of non-granted entries keep updating in the grant cycle under rules 3–6.

## Timing
- Reset values: age_vec=0, active=0, any_active=0, sat=0, grant_err=0, prescale counter=0.
- All outputs are registered or decoded directly from registers; there is no combinational path from inputs to outputs.
- Latency from an input sampled at edge N to the output: visible after edge N, one cycle.
- The arbiter loop age_vec → selector → grant_index → table closes in one cycle. A grant issued in cycle N against age_vec from cycle N clears the entry after edge N.
- With rst asserted mid-operation, all state clears immediately and asynchronously. The first update happens at the first edge after rst deasserts.
- grant_err is a single-cycle pulse. Back-to-back illegal grants produce back-to-back pulses.

## Test plan
- Arrival and aging:
  - Stimulus: WIDTH=4, PRESCALE=0, req=8'h01 held.
  - Required response: age[0] reads 1,2,3,… on successive cycles and saturates at 15; sat[0]=1 from then on; active=8'h01.
- Grant and re-entry:
  - Stimulus: entry 2 at age 5 with req[2] held; pulse grant_valid with index 2.
  - Required response: next cycle age[2]=0 and active[2]=0; the cycle after, age[2]=1. grant_err stays 0.
- Illegal grants:
  - Stimulus: grant index 3 with entry 3 inactive; then, with NUM_INPUTS=6 and INDEX_WIDTH=3, grant index 7.
  - Required response: grant_err pulses once per grant; age_vec is unchanged.
- Priority:
  - Stimulus 1: clear, a grant to active entry 1, and req toggles all in the same cycle.
  - Required response 1: all entries zero next cycle; grant_err=0.
  - Stimulus 2: withdraw req[4] while entry 4 is at age 7.
  - Required response 2: age[4]=0 next cycle.
- Prescale:
  - Stimulus: PRESCALE=2, req[0] held from reset release.
  - Required response: age[0]=1 after arrival, then increments only on every 4th cycle, aligned to the prescale counter reaching 3.
- Async reset:
  - Stimulus: assert rst between edges with several entries active.
  - Required response: every output is 0 before the next edge; normal arrival resumes after release.
